obi_cmd_manager: RTL and testbench

- OBI manager (initiator) that turns a simple valid/ready command stream into OBI A-channel transactions.
- Returns the R-channel responses in order on a valid/ready response stream.
- Drives peripheral register files (e.g. GPIO) from bring-up engines and test sequencers.
- Supports up to MaxOutstanding in-flight transactions; response buffering is credit-protected.

---
 rtl/obi_cmd_mgr_pkg.sv | 33 +++
 rtl/obi_pkg.sv | 42 ++++
 rtl/obi_cmd_mgr_fifo.sv | 52 +++++
 rtl/obi_cmd_manager.sv | 129 ++++++++++++
 tb/tb_obi_cmd_manager.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/obi_cmd_mgr_pkg.sv
// Shared types for obi_cmd_manager: request FSM encoding and FIFO payloads.
package obi_cmd_mgr_pkg;

  localparam int unsigned AddrWidth = obi_pkg::ObiDefaultConfig.AddrWidth;
  localparam int unsigned DataWidth = obi_pkg::ObiDefaultConfig.DataWidth;
  localparam int unsigned IdWidth   = obi_pkg::ObiDefaultConfig.IdWidth;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  typedef struct packed {
    logic [AddrWidth-1:0]   addr;
    logic                   we;
    logic [DataWidth/8-1:0] be;
    logic [DataWidth-1:0]   wdata;
  } cmd_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 err;
    logic                 we;
  } rsp_t;

  typedef struct packed {
    logic [IdWidth-1:0] aid;
    logic               we;
  } exp_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/obi_pkg.sv
// OBI configuration record plus the default-width request/response structs.
package obi_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 4};

  localparam int unsigned ObiAddrWidth = ObiDefaultConfig.AddrWidth;
  localparam int unsigned ObiDataWidth = ObiDefaultConfig.DataWidth;
  localparam int unsigned ObiIdWidth   = ObiDefaultConfig.IdWidth;

  typedef struct packed {
    logic [ObiAddrWidth-1:0]   addr;
    logic                      we;
    logic [ObiDataWidth/8-1:0] be;
    logic [ObiDataWidth-1:0]   wdata;
    logic [ObiIdWidth-1:0]     aid;
  } obi_a_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
    logic        rready;
  } obi_req_t;

  typedef struct packed {
    logic [ObiDataWidth-1:0] rdata;
    logic [ObiIdWidth-1:0]   rid;
    logic                    err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

endpackage

// File: rtl/obi_cmd_mgr_fifo.sv
// Synchronous FIFO, no fall-through; push on full is accepted only with a same-cycle pop.
module obi_cmd_mgr_fifo
  import obi_cmd_mgr_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = cnt_width(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  T                mem [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem[rptr_q];

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_next(wptr_q);
      if (do_pop)  rptr_q <= ptr_next(rptr_q);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr_q] <= data_i;
  end

endmodule

// File: rtl/obi_cmd_manager.sv
// OBI manager: command stream -> OBI A channel, in-order R responses -> response stream.
// Optional rid checking against the issued aid: define OBI_CMD_MGR_RID_CHECK_EN.
module obi_cmd_manager
  import obi_cmd_mgr_pkg::*;
#(
  parameter obi_pkg::obi_cfg_t ObiCfg         = obi_pkg::ObiDefaultConfig,
  parameter type               obi_req_t      = obi_pkg::obi_req_t,
  parameter type               obi_rsp_t      = obi_pkg::obi_rsp_t,
  parameter int unsigned       MaxOutstanding = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  input  logic [ObiCfg.AddrWidth-1:0]     cmd_addr_i,
  input  logic                            cmd_we_i,
  input  logic [ObiCfg.DataWidth/8-1:0]   cmd_be_i,
  input  logic [ObiCfg.DataWidth-1:0]     cmd_wdata_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [ObiCfg.DataWidth-1:0]     rsp_rdata_o,
  output logic                            rsp_err_o,
  output logic                            rsp_we_o,
  output obi_req_t                        obi_req_o,
  input  obi_rsp_t                        obi_rsp_i,
  output logic                            busy_o,
  output logic                            rid_err_o
);

  localparam int unsigned      IdW     = ObiCfg.IdWidth;
  localparam int unsigned      CredW   = $clog2(MaxOutstanding + 1);
  localparam logic [CredW-1:0] CredMax = CredW'(MaxOutstanding);
  localparam logic [IdW-1:0]   IdLast  = IdW'(MaxOutstanding - 1);

  logic [0:0]       state_q;
  cmd_t             hold_q;
  logic [IdW-1:0]   id_q;
  logic [CredW-1:0] cred_q;
  logic             rid_err_q;

  logic accept, issue, rsp_pop, r_take, rid_mismatch;
  exp_t exp_in, exp_head;
  rsp_t rsp_in, rsp_head;
  logic exp_empty, rsp_empty;
  logic unused_exp_full, unused_rsp_full;

  assign issue       = (state_q == REQ) & obi_rsp_i.gnt;
  assign cmd_ready_o = ~rst_i & ((state_q == IDLE) | issue) & (cred_q < CredMax);
  assign accept      = cmd_valid_i & cmd_ready_o;
  assign rsp_valid_o = ~rsp_empty;
  assign rsp_pop     = rsp_valid_o & rsp_ready_i;
  // An rvalid with nothing issued has no expected entry to pair with and is dropped.
  assign r_take      = obi_rsp_i.rvalid & ~exp_empty;

`ifdef OBI_CMD_MGR_RID_CHECK_EN
  assign rid_mismatch = (obi_rsp_i.r.rid != exp_head.aid);
`else
  logic unused_rid;
  assign unused_rid   = ^obi_rsp_i.r.rid;
  assign rid_mismatch = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      id_q      <= '0;
      cred_q    <= '0;
      rid_err_q <= 1'b0;
    end else begin
      if (accept) begin
        hold_q  <= '{addr: cmd_addr_i, we: cmd_we_i, be: cmd_be_i, wdata: cmd_wdata_i};
        state_q <= REQ;
      end else if (issue) begin
        state_q <= IDLE;
      end
      if (issue) id_q <= (id_q == IdLast) ? '0 : id_q + IdW'(1);
      if (accept && !rsp_pop)      cred_q <= cred_q + CredW'(1);
      else if (!accept && rsp_pop) cred_q <= cred_q - CredW'(1);
      if (r_take && rid_mismatch) rid_err_q <= 1'b1;
    end
  end

  always_comb begin
    obi_req_o         = '0;
    obi_req_o.a.addr  = hold_q.addr;
    obi_req_o.a.we    = hold_q.we;
    obi_req_o.a.be    = hold_q.be;
    obi_req_o.a.wdata = hold_q.wdata;
    obi_req_o.a.aid   = id_q;
    obi_req_o.req     = (state_q == REQ);
    obi_req_o.rready  = 1'b1;
  end

  assign exp_in = '{aid: id_q, we: hold_q.we};
  assign rsp_in = '{rdata: exp_head.we ? '0 : obi_rsp_i.r.rdata,
                    err:   obi_rsp_i.r.err | rid_mismatch,
                    we:    exp_head.we};

  obi_cmd_mgr_fifo #(.Depth(MaxOutstanding), .T(exp_t)) i_exp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (issue),
    .data_i  (exp_in),
    .pop_i   (r_take),
    .data_o  (exp_head),
    .full_o  (unused_exp_full),
    .empty_o (exp_empty)
  );

  // Credits bound issued-but-unpopped work, so this FIFO cannot overflow.
  obi_cmd_mgr_fifo #(.Depth(MaxOutstanding), .T(rsp_t)) i_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (r_take),
    .data_i  (rsp_in),
    .pop_i   (rsp_ready_i),
    .data_o  (rsp_head),
    .full_o  (unused_rsp_full),
    .empty_o (rsp_empty)
  );

  assign rsp_rdata_o = rsp_head.rdata;
  assign rsp_err_o   = rsp_head.err;
  assign rsp_we_o    = rsp_head.we;
  assign busy_o      = (state_q == REQ) | (cred_q != '0);
  assign rid_err_o   = rid_err_q;

endmodule

// File: tb/tb_obi_cmd_manager.sv
// Randomised scoreboard bench for obi_cmd_manager with a memory-backed OBI subordinate.
module tb_obi_cmd_manager;
  import obi_pkg::*;

  localparam int unsigned MaxOut  = 4;
  localparam int unsigned IdW     = ObiDefaultConfig.IdWidth;
  localparam logic [31:0] ErrBase = 32'h0000_0100;
  localparam logic [31:0] ErrData = 32'hBADC_AB1E;
`ifdef OBI_CMD_MGR_RID_CHECK_EN
  localparam bit RidEn = 1'b1;
`else
  localparam bit RidEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i, cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i, rsp_rdata_o;
  logic [3:0]  cmd_be_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_we_o, busy_o, rid_err_o;
  obi_req_t    obi_req_o;
  obi_rsp_t    obi_rsp_i;

  always #5 clk = ~clk;

  obi_cmd_manager #(
    .ObiCfg(ObiDefaultConfig), .obi_req_t(obi_req_t), .obi_rsp_t(obi_rsp_t), .MaxOutstanding(MaxOut)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
    .cmd_we_i(cmd_we_i), .cmd_be_i(cmd_be_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_we_o(rsp_we_o),
    .obi_req_o(obi_req_o), .obi_rsp_i(obi_rsp_i),
    .busy_o(busy_o), .rid_err_o(rid_err_o)
  );

  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; bit corrupt; } tcmd_t;
  typedef struct { logic [31:0] rdata; logic err; logic we; } trsp_t;
  typedef struct { logic [31:0] rdata; logic err; logic [IdW-1:0] rid; int unsigned due; bit stale; bit corrupt; } sub_t;

  tcmd_t cmd_q[$];
  trsp_t exp_q[$];
  sub_t  sub_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] sub_mem [logic [31:0]];

  int          n_checks = 0, n_errors = 0;
  int unsigned cyc = 0, issued = 0, max_dly = 3;
  int          outstanding = 0;
  bit          rid_model, exp_req, exp_rv, prev_stall, post_rst, cmd_fired, corrupt_next;
  logic [127:0] prev_a;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return 32'h5A00_0000 ^ (a * 32'h0101_0101);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic bit is_err(input logic [31:0] a);
    return a >= ErrBase;
  endfunction

  // Expected response of a command, decided when the command is accepted.
  function automatic trsp_t predict(input tcmd_t c);
    trsp_t r;
    logic [31:0] old;
    old     = ref_mem.exists(c.addr) ? ref_mem[c.addr] : init_word(c.addr);
    r.we    = c.we;
    r.err   = is_err(c.addr) || (RidEn && c.corrupt);
    r.rdata = '0;
    if (is_err(c.addr)) begin
      if (!c.we) r.rdata = ErrData;
    end else if (c.we) ref_mem[c.addr] = merge(old, c.wdata, c.be);
    else r.rdata = old;
    return r;
  endfunction

  // Subordinate behaviour at grant time; write responses carry garbage rdata.
  function automatic sub_t sub_issue(input obi_a_chan_t a, input bit corrupt);
    sub_t s;
    logic [31:0] old;
    old       = sub_mem.exists(a.addr) ? sub_mem[a.addr] : init_word(a.addr);
    s.err     = is_err(a.addr);
    s.stale   = 1'b0;
    s.corrupt = corrupt;
    s.rid     = corrupt ? (a.aid ^ IdW'(2)) : a.aid;
    s.due     = cyc + 1 + $urandom_range(0, max_dly);
    if (s.err) s.rdata = ErrData;
    else if (a.we) begin
      sub_mem[a.addr] = merge(old, a.wdata, a.be);
      s.rdata = $urandom;
    end else s.rdata = old;
    return s;
  endfunction

  task automatic drive_cycle(input int valid_pct, input int gnt_pct, input int rready_pct, input int err_pct);
    bit hold;
    @(posedge clk); #1; cyc++;
    hold = 1'b0;
    foreach (sub_q[i]) if (sub_q[i].stale) hold = 1'b1;
    if (!cmd_valid_i || cmd_fired) begin
      cmd_fired = 1'b0;
      if (!hold && int'($urandom_range(0, 99)) < valid_pct) begin
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'($urandom_range(0, 1));
        cmd_be_i    = 4'($urandom_range(1, 15));
        cmd_wdata_i = $urandom;
        cmd_addr_i  = (int'($urandom_range(0, 99)) < err_pct) ? ErrBase + 32'(4 * $urandom_range(0, 3))
                                                               : 32'(4 * $urandom_range(0, 15));
      end else cmd_valid_i = 1'b0;
    end
    obi_rsp_i.gnt = (int'($urandom_range(0, 99)) < gnt_pct);
    rsp_ready_i   = (int'($urandom_range(0, 99)) < rready_pct);
    if (sub_q.size() > 0 && sub_q[0].due <= cyc) begin
      obi_rsp_i.rvalid  = 1'b1;
      obi_rsp_i.r.rdata = sub_q[0].rdata;
      obi_rsp_i.r.rid   = sub_q[0].rid;
      obi_rsp_i.r.err   = sub_q[0].err;
    end else begin
      obi_rsp_i.rvalid = 1'b0;
      obi_rsp_i.r      = '0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1; cyc++;
    rst_i = 1'b1; cmd_valid_i = 1'b0; rsp_ready_i = 1'b0;
    obi_rsp_i.gnt = 1'b0; obi_rsp_i.rvalid = 1'b0;
    @(posedge clk); #1; cyc++;
    rst_i = 1'b0;
  endtask

  // Monitor: checks DUT state at the negedge and predicts the handshakes of the next posedge.
  initial begin
    tcmd_t c;
    trsp_t e;
    sub_t  s;
    logic [127:0] a_now;
    forever begin
      @(negedge clk);
      a_now = '0;
      a_now[$bits(obi_a_chan_t)-1:0] = obi_req_o.a;
      if (rst_i) begin
        chk("ready_in_reset", cmd_ready_o, 0);
        cmd_q.delete(); exp_q.delete();
        foreach (sub_q[i]) sub_q[i].stale = 1'b1;
        ref_mem = sub_mem;
        outstanding = 0; issued = 0; rid_model = 0;
        exp_req = 0; exp_rv = 0; prev_stall = 0; cmd_fired = 0; post_rst = 1;
        continue;
      end
      if (post_rst) begin
        chk("rst_req", obi_req_o.req, 0);
        chk("rst_a", a_now, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_rid_err", rid_err_o, 0);
        post_rst = 0;
      end
      chk("busy", busy_o, outstanding != 0);
      chk("cmd_ready", cmd_ready_o, (outstanding < int'(MaxOut)) && (!obi_req_o.req || obi_rsp_i.gnt));
      chk("rid_err", rid_err_o, rid_model);
      chk("rready", obi_req_o.rready, 1);
      chk("spurious_rsp", rsp_valid_o && exp_q.size() == 0, 0);
      if (exp_req) chk("req_latency", obi_req_o.req, 1);
      if (exp_rv) chk("rsp_latency", rsp_valid_o, 1);
      if (prev_stall) begin
        chk("req_held", obi_req_o.req, 1);
        chk("a_stable", a_now, prev_a);
      end
      exp_req = 0; exp_rv = 0; prev_stall = 0;

      if (rsp_valid_o && rsp_ready_i && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata_o, e.rdata);
        chk("rsp_err", rsp_err_o, e.err);
        chk("rsp_we", rsp_we_o, e.we);
        outstanding--;
      end
      if (cmd_valid_i && cmd_ready_o) begin
        c = '{addr: cmd_addr_i, we: cmd_we_i, be: cmd_be_i, wdata: cmd_wdata_i, corrupt: corrupt_next};
        corrupt_next = 0;
        cmd_q.push_back(c);
        exp_q.push_back(predict(c));
        outstanding++;
        cmd_fired = 1;
        exp_req = 1;
      end
      if (obi_req_o.req) begin
        if (cmd_q.size() == 0) chk("req_without_cmd", 1, 0);
        else if (obi_rsp_i.gnt) begin
          c = cmd_q.pop_front();
          chk("a_addr", obi_req_o.a.addr, c.addr);
          chk("a_we", obi_req_o.a.we, c.we);
          chk("a_be", obi_req_o.a.be, c.be);
          chk("a_wdata", obi_req_o.a.wdata, c.wdata);
          chk("a_aid", obi_req_o.a.aid, issued % MaxOut);
          issued++;
          sub_q.push_back(sub_issue(obi_req_o.a, c.corrupt));
        end else begin
          prev_stall = 1;
          prev_a = a_now;
        end
      end
      if (obi_rsp_i.rvalid && sub_q.size() > 0) begin
        s = sub_q.pop_front();
        if (!s.stale) begin
          exp_rv = 1;
          if (RidEn && s.corrupt) rid_model = 1;
        end
      end
    end
  end

  initial begin
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_we_i = 1'b0; cmd_be_i = '0;
    cmd_wdata_i = '0; rsp_ready_i = 1'b0; obi_rsp_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    // Fill to the credit limit with responses held back, then release.
    max_dly = 3;
    repeat (20) drive_cycle(100, 100, 0, 0);
    repeat (30) drive_cycle(100, 100, 100, 0);
    // Mixed traffic including error-region accesses.
    max_dly = 4;
    repeat (300) drive_cycle(60, 60, 70, 15);
    // Long grant stalls.
    repeat (100) drive_cycle(80, 15, 60, 10);
    // One response with a wrong rid.
    corrupt_next = 1'b1;
    repeat (60) drive_cycle(70, 70, 70, 0);
    // Reset with work in flight and responses still owed.
    max_dly = 6;
    repeat (8) drive_cycle(100, 50, 0, 0);
    do_reset();
    max_dly = 3;
    repeat (200) drive_cycle(60, 60, 60, 10);
    // Drain.
    for (int i = 0; i < 400 && (exp_q.size() > 0 || sub_q.size() > 0 || cmd_valid_i); i++)
      drive_cycle(0, 100, 100, 0);
    chk("drain_timeout", exp_q.size() + sub_q.size(), 0);
    repeat (2) drive_cycle(0, 100, 100, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
